// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Fetch front end for the IF/ID register. Issues word-addressed reads to an
//   in-order, variable-latency instruction memory. Returned words are buffered
//   in a FIFO and presented to decode together with their NPC (PC+1).
//   Handles branch redirects, load-use stalls and stops fetching after HLT.
//
// Ports
//   clk1, rst            clock; synchronous active-high reset
//   imem_req_*           read request (valid/ready, word address)
//   imem_rsp_*           read response, in request order
//   redirect_valid/pc    taken branch: flush and refetch from redirect_pc
//   stall                hold the head entry
//   if_valid/ir/npc      head entry for decode
//   halt_seen            HLT has been enqueued; fetching stopped
//   fifo_count           occupied FIFO entries
//
// Optional build macro FETCH_STATS_EN adds stat_fetched, stat_discarded and
// stat_stall_cyc free-running counters.
module instr_prefetch_queue #(
  parameter int             AW       = 10,
  parameter int             DEPTH    = 4,
  parameter int             MAX_OUT  = 2,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                       clk1,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [AW-1:0]              imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [AW-1:0]              redirect_pc,
  input  logic                       stall,
  output logic                       if_valid,
  output logic [31:0]                if_ir,
  output logic [31:0]                if_npc,
  output logic                       halt_seen,
  output logic [$clog2(DEPTH):0]     fifo_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                stat_fetched,
  output logic [31:0]                stat_discarded,
  output logic [31:0]                stat_stall_cyc
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;  // pointer width, extra MSB for full/empty
  localparam int IW = PW - 1;             // storage index width
  localparam int CW = 2;                  // in-flight counters, MAX_OUT <= 3
  localparam logic [5:0] OP_HLT = 6'b111111;

  typedef struct packed {
    logic [31:0]   ir;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t            fifo [DEPTH];
  ent_t            head;
  logic [PW-1:0]   wptr, rptr, count;
  logic [AW-1:0]   fetch_pc;
  logic [AW-1:0]   rsp_pc;       // PC of the next response that will be kept
  logic [CW-1:0]   outstanding;  // in-flight requests whose data will be kept
  logic [CW-1:0]   discard;      // in-flight requests whose data will be dropped
  logic [CW-1:0]   out_nxt, dis_nxt;
  logic            halt_q;
  logic            empty, full, req_fire, drop, push, pop, is_hlt;
  logic [PW:0]     occ;
  logic [CW:0]     infl;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
  // FIFO space is reserved for every kept request still in flight.
  assign occ   = (PW+1)'(count) + (PW+1)'(outstanding);
  // Dropped requests still occupy the memory pipe, so they count toward MAX_OUT.
  assign infl  = (CW+1)'(outstanding) + (CW+1)'(discard);

  assign imem_req_valid = !rst && !redirect_valid && !halt_q
                          && (infl < (CW+1)'(MAX_OUT)) && (occ < (PW+1)'(DEPTH));
  assign imem_req_addr  = rst ? RESET_PC : fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign drop   = imem_rsp_valid && !redirect_valid && (discard != '0);
  assign push   = imem_rsp_valid && !rst && !redirect_valid && (discard == '0);
  assign is_hlt = (imem_rsp_data[31:26] == OP_HLT);
  assign pop    = !empty && !stall && !redirect_valid;

  always_comb begin
    out_nxt = outstanding;
    dis_nxt = discard;
    if (redirect_valid) begin
      // Everything in flight becomes garbage; a response arriving now is
      // consumed from that total whichever counter it belonged to.
      out_nxt = '0;
      dis_nxt = discard + outstanding - CW'(imem_rsp_valid);
    end else if (push && is_hlt) begin
      // discard is zero whenever a push happens; younger requests, including
      // one accepted this very cycle, are all dropped.
      out_nxt = '0;
      dis_nxt = outstanding - 1'b1 + CW'(req_fire);
    end else begin
      out_nxt = outstanding + CW'(req_fire) - CW'(push);
      dis_nxt = discard - CW'(drop);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      halt_q      <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      outstanding <= out_nxt;
      discard     <= dis_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        halt_q   <= 1'b0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 1'b1;
        if (push) begin
          rsp_pc <= rsp_pc + 1'b1;
          wptr   <= wptr + 1'b1;
          if (is_hlt) halt_q <= 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (push) fifo[wptr[IW-1:0]] <= '{ir: imem_rsp_data, pc: rsp_pc};
  end

  assign head       = fifo[rptr[IW-1:0]];
  assign if_valid   = !rst && !empty;
  assign if_ir      = if_valid ? head.ir : '0;
  assign if_npc     = if_valid ? (32'(head.pc) + 32'd1) : '0;
  assign halt_seen  = halt_q && !rst;
  assign fifo_count = rst ? '0 : count;

  always_ff @(posedge clk1) begin
    if (!rst) begin
      assert (infl <= (CW+1)'(MAX_OUT));
      assert (!(push && full));
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, discarded_q, stall_q;
  logic        rsp_drop;

  // A response landing in a redirect cycle is dropped as well.
  assign rsp_drop = imem_rsp_valid && (redirect_valid || (discard != '0));

  always_ff @(posedge clk1) begin
    if (rst) begin
      fetched_q   <= '0;
      discarded_q <= '0;
      stall_q     <= '0;
    end else begin
      if (push)              fetched_q   <= fetched_q + 32'd1;
      if (rsp_drop)          discarded_q <= discarded_q + 32'd1;
      if (if_valid && stall) stall_q     <= stall_q + 32'd1;
    end
  end

  assign stat_fetched   = fetched_q;
  assign stat_discarded = discarded_q;
  assign stat_stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: in-order memory model with random latency,
// ISA-level expected instruction stream (sequential PCs from reset/redirect
// target up to and including HLT) checked by a separate monitor.
module tb_instr_prefetch_queue;
  localparam int AW = 10, DEPTH = 4, MAX_OUT = 2;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic clk1 = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [AW-1:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic stall = 1'b0;
  logic if_valid, halt_seen;
  logic [31:0] if_ir, if_npc;
  logic [$clog2(DEPTH):0] fifo_count;

  instr_prefetch_queue #(.AW(AW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk1(clk1), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc),
    .halt_seen(halt_seen), .fifo_count(fifo_count));

  always #5 clk1 = ~clk1;

  typedef struct { int pc; logic [31:0] ir; logic [31:0] npc; } exp_t;
  typedef struct { logic [AW-1:0] addr; int due; } pend_t;

  logic [31:0] mem [1024];
  exp_t  exp_q[$];
  pend_t pend[$];
  int exp_pc = 0, cyc = 0, last_due = 0, npops = 0;
  bit exp_done = 0, tb_halted = 0, prev_hold = 0;
  logic [AW-1:0] exp_req_addr = RESET_PC;
  logic [31:0] prev_ir = '0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit hlt(input logic [31:0] w);
    return w[31:26] == 6'h3f;
  endfunction

  // Expected decode stream: consecutive words from exp_pc, ending at HLT.
  task automatic topup();
    while (!exp_done && exp_q.size() < 16) begin
      exp_t e;
      e.pc  = exp_pc;
      e.ir  = mem[exp_pc];
      e.npc = 32'(exp_pc) + 32'd1;
      exp_q.push_back(e);
      if (hlt(e.ir)) exp_done = 1;
      exp_pc = (exp_pc + 1) % 1024;
    end
  endtask

  task automatic restart(input int pc);
    exp_q.delete();
    exp_pc = pc;
    exp_done = 0;
    tb_halted = 0;
    exp_req_addr = AW'(pc);
  endtask

  // One clock cycle of stimulus plus the memory model.
  task automatic step(input bit rs, input bit st, input bit rd, input int tgt,
                      input bit rdy, input int lat);
    @(posedge clk1); #1;
    cyc++;
    rst = rs;
    stall = st;
    redirect_valid = rd && !rs;
    redirect_pc = AW'(tgt);
    imem_req_ready = rdy;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = $urandom;
    if (rs) begin
      pend.delete();
      last_due = 0;
      npops = 0;
      restart(int'(RESET_PC));
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem[pend[0].addr];
        void'(pend.pop_front());
      end
      if (rd) restart(tgt);
    end
    topup();
    @(negedge clk1);
    if (!rs && imem_req_valid && imem_req_ready) begin
      int d;
      chk("req_addr", 64'(imem_req_addr), 64'(exp_req_addr));
      if (tb_halted) chk("req_after_halt", 64'(imem_req_valid), 64'd0);
      exp_req_addr = exp_req_addr + 1'b1;
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: imem_req_addr, due: d});
      chk("inflight_le_max", 64'(pend.size() <= MAX_OUT), 64'd1);
    end
    #1;
  endtask

  // Monitor: compares every word decode consumes against the expected stream.
  always @(negedge clk1) begin
    if (rst) begin
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_halt_seen", 64'(halt_seen), 64'd0);
      chk("rst_if_ir", 64'(if_ir), 64'd0);
      chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid_hold", 64'(if_valid), 64'd1);
        chk("stall_ir_hold", 64'(if_ir), 64'(prev_ir));
      end
      if (if_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("pop_beyond_halt", 64'(if_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          npops++;
          chk("if_ir", 64'(if_ir), 64'(e.ir));
          chk("if_npc", 64'(if_npc), 64'(e.npc));
          if (hlt(e.ir)) begin
            chk("halt_seen_at_hlt", 64'(halt_seen), 64'd1);
            tb_halted = 1;
          end
        end
      end
      if (tb_halted && !redirect_valid) chk("halt_seen_held", 64'(halt_seen), 64'd1);
      prev_hold = if_valid && stall && !redirect_valid;
      prev_ir = if_ir;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (hlt(w)) w[31] = 1'b0;
      mem[i] = w;
    end
    mem[2]  = 32'hFC000000;
    mem[40] = 32'hFC000123;
    for (int k = 0; k < 8; k++) mem[$urandom_range(500, 1000)] = {6'h3f, 26'($urandom)};

    // Reset, latency 1, always ready: first word visible on the third cycle
    // after release; HLT at word 2 stops fetching after words 0,1,2.
    repeat (3) step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 1);
      chk("first_valid_latency", 64'(if_valid), 64'(i >= 2));
    end
    repeat (15) step(0, 0, 0, 0, 1, 1);
    chk("hlt_halt_seen", 64'(halt_seen), 64'd1);
    chk("hlt_drained", 64'(if_valid), 64'd0);
    chk("hlt_no_req", 64'(imem_req_valid), 64'd0);
    chk("hlt_words_delivered", 64'(npops), 64'd3);

    // Long stall: FIFO fills to DEPTH and requests stop.
    step(0, 0, 1, 100, 1, 1);
    repeat (10) step(0, 1, 0, 0, 1, 1);
    chk("stall_fifo_full", 64'(fifo_count), 64'(DEPTH));
    chk("stall_req_stopped", 64'(imem_req_valid), 64'd0);
    repeat (20) step(0, 0, 0, 0, 1, 1);

    // Memory not ready: address held, no advance.
    step(0, 0, 1, 300, 0, 1);
    repeat (4) begin
      step(0, 0, 0, 0, 0, 1);
      chk("not_ready_addr", 64'(imem_req_addr), 64'd300);
      chk("not_ready_valid", 64'(imem_req_valid), 64'd1);
    end
    repeat (20) step(0, 0, 0, 0, 1, 1);

    // Latency 3, requests to 4 and 5 in flight, then redirect to 20.
    step(0, 0, 1, 4, 1, 3);
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 1, 20, 1, 3);
    repeat (30) step(0, 0, 0, 0, 1, 3);

    // Address wrap: 1022, 1023, 0, 1, 2 (HLT).
    step(0, 0, 1, 1022, 1, 2);
    repeat (20) step(0, 0, 0, 0, 1, 2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 3) begin
        repeat (2) step(1, 0, 0, 0, 1, 1);
      end else begin
        step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 1023), $urandom_range(0, 3) != 0, $urandom_range(1, 4));
      end
    end
    repeat (40) step(0, 0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
